// File: rtl/lcd_spi_pkg.sv
// Shared definitions for the LCD SPI write path: arbiter state encoding and engine op codes.
package lcd_spi_pkg;

   typedef enum logic [3:0] {
      StIdle = 4'b0001,
      StWait = 4'b0010,
      StGap  = 4'b0100,
      StHold = 4'b1000
   } arb_state_e;

   localparam logic [1:0]  EN_WR      = 2'b01;
   localparam logic [1:0]  EN_RST     = 2'b10;
   localparam int unsigned LCD_WORD_W = 9;

endpackage

// File: rtl/lcd_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from last+1 (wrapping).
module lcd_rr_pick #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IdxW-1:0]    last,
   output logic               valid,
   output logic [NUM_REQ-1:0] grant,
   output logic [IdxW-1:0]    idx
);

   logic [IdxW-1:0] cand;

   always_comb begin
      valid = 1'b0;
      grant = '0;
      idx   = '0;
      cand  = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         cand = IdxW'((int'(last) + 1 + i) % int'(NUM_REQ));
         if (!valid && req[cand]) begin
            valid       = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule

// File: rtl/lcd_spi_arbiter.sv
// Round-robin arbiter sharing one LCD SPI write engine between NUM_REQ requesters,
// with per-requester lock for burst ownership and a done watchdog.
module lcd_spi_arbiter
   import lcd_spi_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 2,
   parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [2*NUM_REQ-1:0]          req_en_i,
   input  logic [LCD_WORD_W*NUM_REQ-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]            req_lock_i,
   output logic [NUM_REQ-1:0]            req_grant_o,
   output logic [2*NUM_REQ-1:0]          req_done_o,
   output logic [NUM_REQ-1:0]            req_err_o,
   output logic [1:0]                    en_o,
   output logic [LCD_WORD_W-1:0]         data_o,
   input  logic [1:0]                    done_i,
   output logic                          busy_o
);

   localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned TimerW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYC - 1);
   localparam logic [IdxW-1:0]   LastRst  = IdxW'(NUM_REQ - 1);

   logic [NUM_REQ-1:0][1:0]            req_en_a;
   logic [NUM_REQ-1:0][LCD_WORD_W-1:0] req_data_a;
   logic [NUM_REQ-1:0]                 cand;

   assign req_en_a   = req_en_i;
   assign req_data_a = req_data_i;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_cand
      assign cand[g] = |req_en_a[g];
   end

   arb_state_e                state_q, state_d;
   logic [1:0]                en_q, en_d;
   logic [LCD_WORD_W-1:0]     data_q, data_d;
   logic [NUM_REQ-1:0]        grant_q, grant_d;
   logic [NUM_REQ-1:0][1:0]   done_q, done_d;
   logic [NUM_REQ-1:0]        err_q, err_d;
   logic [IdxW-1:0]           last_q, last_d;
   logic [TimerW-1:0]         timer_q, timer_d;
   logic                      release_q, release_d;
   logic                      busy_q;

   logic                      pick_valid;
   logic [NUM_REQ-1:0]        pick_grant;
   logic [IdxW-1:0]           pick_idx;

   lcd_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IdxW    (IdxW)
   ) u_pick (
      .req   (cand),
      .last  (last_q),
      .valid (pick_valid),
      .grant (pick_grant),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d   = state_q;
      en_d      = en_q;
      data_d    = data_q;
      grant_d   = grant_q;
      done_d    = '0;
      err_d     = '0;
      last_d    = last_q;
      timer_d   = timer_q;
      release_d = release_q;

      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               en_d      = req_en_a[pick_idx];
               data_d    = req_data_a[pick_idx];
               grant_d   = pick_grant;
               last_d    = pick_idx;
               timer_d   = '0;
               release_d = 1'b0;
               state_d   = StWait;
            end
         end
         StWait: begin
            if ((done_i & en_q) != 2'b00) begin
               en_d           = 2'b00;
               done_d[last_q] = done_i & en_q;
               state_d        = StGap;
            end else if (timer_q == TimerMax) begin
               // Abort: a hung engine must not let a locked owner keep the bus.
               en_d          = 2'b00;
               err_d[last_q] = 1'b1;
               release_d     = 1'b1;
               state_d       = StGap;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StGap: begin
            release_d = 1'b0;
            if (req_lock_i[last_q] && !release_q) begin
               timer_d = '0;
               state_d = StHold;
            end else begin
               grant_d = '0;
               state_d = StIdle;
            end
         end
         StHold: begin
            if (cand[last_q]) begin
               en_d    = req_en_a[last_q];
               data_d  = req_data_a[last_q];
               timer_d = '0;
               state_d = StWait;
            end else if (!req_lock_i[last_q]) begin
               grant_d = '0;
               state_d = StIdle;
            end else if (timer_q == TimerMax) begin
               err_d[last_q] = 1'b1;
               grant_d       = '0;
               state_d       = StIdle;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin
            en_d    = 2'b00;
            grant_d = '0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         en_q      <= 2'b00;
         data_q    <= '0;
         grant_q   <= '0;
         done_q    <= '0;
         err_q     <= '0;
         last_q    <= LastRst;
         timer_q   <= '0;
         release_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         en_q      <= en_d;
         data_q    <= data_d;
         grant_q   <= grant_d;
         done_q    <= done_d;
         err_q     <= err_d;
         last_q    <= last_d;
         timer_q   <= timer_d;
         release_q <= release_d;
         busy_q    <= (state_d != StIdle);
      end
   end

   assign en_o        = en_q;
   assign data_o      = data_q;
   assign req_grant_o = grant_q;
   assign req_done_o  = done_q;
   assign req_err_o   = err_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_lcd_spi_arbiter.sv
// Directed bench for lcd_spi_arbiter with two requesters and a short watchdog.
module tb_lcd_spi_arbiter;
   import lcd_spi_pkg::*;

   localparam int unsigned NUM_REQ     = 2;
   localparam int unsigned TIMEOUT_CYC = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_en;
   logic [17:0] req_data;
   logic [1:0]  req_lock;
   logic [1:0]  req_grant;
   logic [3:0]  req_done;
   logic [1:0]  req_err;
   logic [1:0]  en;
   logic [8:0]  data;
   logic [1:0]  done;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;

   logic [8:0] words [3];

   lcd_spi_arbiter #(
      .NUM_REQ     (NUM_REQ),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_en_i    (req_en),
      .req_data_i  (req_data),
      .req_lock_i  (req_lock),
      .req_grant_o (req_grant),
      .req_done_o  (req_done),
      .req_err_o   (req_err),
      .en_o        (en),
      .data_o      (data),
      .done_i      (done),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      req_en   = '0;
      req_data = '0;
      req_lock = '0;
      done     = '0;
      words[0] = 9'h02A;
      words[1] = 9'h100;
      words[2] = 9'h17F;
      do_reset();
      check("rst_grant", req_grant, 0);
      check("rst_en", en, 0);
      check("rst_busy", busy, 0);
      check("rst_done", req_done, 0);

      // Single write from requester 0
      req_en[1:0]  = EN_WR;
      req_data[8:0] = 9'h02C;
      tick();
      check("t1_en", en, 2'b01);
      check("t1_data", data, 9'h02C);
      check("t1_grant", req_grant, 2'b01);
      check("t1_busy", busy, 1);
      for (int i = 0; i < 4; i++) tick();
      check("t1_en_held", en, 2'b01);
      done = 2'b01;
      tick();
      done = 2'b00;
      check("t1_done", req_done, 4'b0001);
      check("t1_en_drop", en, 0);
      check("t1_grant_gap", req_grant, 2'b01);
      req_en = '0;
      tick();
      check("t1_grant_clr", req_grant, 0);
      check("t1_done_pulse", req_done, 0);
      check("t1_idle", busy, 0);

      // Alternating grants with both requesters always asking
      do_reset();
      req_en   = {EN_WR, EN_WR};
      req_data = {9'h122, 9'h011};
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t2_grant", req_grant, (i % 2 == 0) ? 2'b01 : 2'b10);
         check("t2_data", data, (i % 2 == 0) ? 9'h011 : 9'h122);
         done = 2'b01;
         tick();
         done = 2'b00;
         check("t2_done", req_done, (i % 2 == 0) ? 4'b0001 : 4'b0100);
         tick();
      end
      req_en = '0;

      // Locked burst from requester 0 while requester 1 waits
      req_en[3:2]    = EN_WR;
      req_data[17:9] = 9'h155;
      req_en[1:0]    = EN_WR;
      req_lock[0]    = 1'b1;
      req_data[8:0]  = words[0];
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t3_grant", req_grant, 2'b01);
         check("t3_data", data, words[i]);
         done = 2'b01;
         tick();
         done = 2'b00;
         check("t3_done", req_done, 4'b0001);
         if (i < 2) req_data[8:0] = words[i+1];
         else req_en[1:0] = 2'b00;
         tick();
      end
      tick();
      check("t3_hold_grant", req_grant, 2'b01);
      check("t3_hold_en", en, 0);
      req_lock[0] = 1'b0;
      tick();
      check("t3_unlock", req_grant, 0);
      tick();
      check("t3_req1_grant", req_grant, 2'b10);
      check("t3_req1_data", data, 9'h155);
      done = 2'b01;
      tick();
      done = 2'b00;
      check("t3_req1_done", req_done, 4'b0100);
      req_en = '0;
      tick();

      // Watchdog on an LCD reset op from requester 1; lock must be discarded
      req_en[3:2] = EN_RST;
      req_lock[1] = 1'b1;
      tick();
      check("t4_en", en, 2'b10);
      check("t4_grant", req_grant, 2'b10);
      req_en[1:0]   = EN_WR;
      req_data[8:0] = 9'h0AA;
      for (int i = 0; i < 15; i++) tick();
      check("t4_en_before", en, 2'b10);
      check("t4_err_before", req_err, 0);
      tick();
      check("t4_en_abort", en, 0);
      check("t4_err", req_err, 2'b10);
      check("t4_no_done", req_done, 0);
      req_en[3:2] = 2'b00;
      tick();
      check("t4_err_pulse", req_err, 0);
      check("t4_released", req_grant, 0);
      tick();
      check("t4_req0_grant", req_grant, 2'b01);
      check("t4_req0_data", data, 9'h0AA);
      done = 2'b01;
      tick();
      done = 2'b00;
      check("t4_req0_done", req_done, 4'b0001);
      req_en   = '0;
      req_lock = '0;
      tick();

      // Non-matching done bit is ignored
      req_en[1:0]   = EN_WR;
      req_data[8:0] = 9'h033;
      tick();
      done = 2'b10;
      tick();
      done = 2'b00;
      check("t5_ignore_en", en, 2'b01);
      check("t5_ignore_done", req_done, 0);
      check("t5_ignore_busy", busy, 1);
      tick();
      done = 2'b01;
      tick();
      done = 2'b00;
      check("t5_done", req_done, 4'b0001);
      req_en = '0;
      tick();

      // en=11 completes on either done bit
      req_en[3:2] = 2'b11;
      tick();
      check("t5b_en", en, 2'b11);
      done = 2'b10;
      tick();
      done = 2'b00;
      check("t5b_done", req_done, 4'b1000);
      req_en = '0;
      tick();

      // Asynchronous reset mid-WAIT, stale done afterwards
      req_en[1:0]   = EN_WR;
      req_data[8:0] = 9'h1FF;
      tick();
      check("t6_en", en, 2'b01);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_en", en, 0);
      check("t6_rst_grant", req_grant, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_data", data, 0);
      req_en = '0;
      rst = 1'b0;
      done = 2'b01;
      tick();
      done = 2'b00;
      check("t6_stale", req_done, 0);
      check("t6_stale_busy", busy, 0);
      req_en   = {EN_WR, EN_WR};
      req_data = {9'h101, 9'h0F0};
      tick();
      check("t6_first", req_grant, 2'b01);
      check("t6_first_data", data, 9'h0F0);
      done = 2'b01;
      tick();
      done = 2'b00;
      req_en = '0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
